// File: rtl/frame_scheduler.sv
// Frame sequencer: prescaled frame timer that steps the game grid, starts one LED refresh
// per frame and tracks channel completion with timeout, overrun and frame-count status.
module frame_scheduler #(
    parameter int CLK_DIV       = 2,
    parameter int FRAME_TICKS   = 500000,
    parameter int ENABLE_CYCLES = 2,
    parameter int NUM_CH        = 2,
    parameter int TIMEOUT       = 4096,
    parameter int CNT_W         = 21
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [NUM_CH-1:0] ch_finished,
    input  logic              clr_status,
    output logic              game_enable,
    output logic              led_start,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err,
    output logic [15:0]       frame_count,
    output logic [2:0]        state_dbg
);

    localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0]  EN_LAST    = CNT_W'(ENABLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENABLE = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0]    frame_q, frame_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [15:0]         fc_q, fc_d;
    logic                ovr_q, ovr_d;
    logic                to_q, to_d;

    logic                ce;
    logic                frame_tick;
    logic [NUM_CH-1:0]   done_now;

    assign ce         = (presc_q == PRE_LAST);
    assign frame_tick = ce && (frame_q == FRAME_LAST);
    // Completion includes this cycle's flags so a channel finishing now is not missed.
    assign done_now   = done_q | ch_finished;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            frame_q <= '0;
            wait_q  <= '0;
            done_q  <= '0;
            fc_q    <= '0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            frame_q <= frame_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            fc_q    <= fc_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = ce ? '0 : presc_q + 1'b1;
        frame_d = frame_q;
        wait_d  = wait_q;
        done_d  = done_q;
        fc_d    = fc_q;
        // Clear first, then any set condition below overrides it.
        ovr_d   = ovr_q & ~clr_status;
        to_d    = to_q & ~clr_status;

        if (ce) begin
            frame_d = frame_tick ? '0 : frame_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                frame_d = '0;
                if (run) begin
                    state_d = S_ENABLE;
                end
            end
            S_ENABLE: begin
                if (ce && (frame_q == EN_LAST)) begin
                    state_d = S_START;
                    fc_d    = fc_q + 16'd1;
                end
            end
            S_START: begin
                done_d  = '0;
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                done_d = done_now;
                if (TIMEOUT != 0) begin
                    wait_d = wait_q + 1'b1;
                end
                if (frame_tick) begin
                    ovr_d = 1'b1;
                end
                if (&done_now) begin
                    state_d = S_HOLD;
                end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                    to_d    = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (frame_tick) begin
                    state_d = run ? S_ENABLE : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign game_enable = (state_q == S_ENABLE);
    assign led_start   = (state_q == S_START);
    assign busy        = (state_q == S_START) || (state_q == S_WAIT);
    assign overrun     = ovr_q;
    assign timeout_err = to_q;
    assign frame_count = fc_q;
    assign state_dbg   = state_q;

endmodule
